down_timer: RTL and testbench

Programmable, loadable down-counter/timer and the count-down complement to the free-running up counter. It loads a start value, decrements on enabled cycles, and flags expiry with a one-cycle pulse. It runs either one-shot or auto-reload, so it can time intervals, generate periodic ticks and gate downstream blocks.

---
 rtl/down_timer_pkg.sv | 21 ++
 rtl/down_timer.sv | 114 +++++++++++
 tb/tb_down_timer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_timer_pkg                                             |
// | Description : Shared types and constants for the down_timer block.       |
// |               Holds the state encoding and the default counter width.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package down_timer_pkg;

   // Default counter/load-value width in bits
   localparam int DEFAULT_WIDTH = 4;

   // Timer state encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : down_timer_pkg
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_timer                                                 |
// | Description : Programmable, loadable down-counter/timer with one-shot    |
// |               and auto-reload modes and a registered one-cycle expiry    |
// |               pulse.                                                     |
// | Ports       : clk         - system clock, rising edge                    |
// |               reset       - asynchronous active-high reset               |
// |               load        - load strobe (highest priority)               |
// |               load_value  - start/period value captured on load          |
// |               auto_reload - 0 = one-shot, 1 = periodic                   |
// |               en          - count enable, one decrement per enabled edge |
// |               Q           - current count (registered)                   |
// |               expire      - one-cycle pulse when Q first reaches 0       |
// |               busy        - high while counting                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module down_timer
   import down_timer_pkg::*;
#(
   parameter int n = DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [n-1:0] load_value,
   input  logic         auto_reload,
   input  logic         en,
   output logic [n-1:0] Q,
   output logic         expire,
   output logic         busy
);

   localparam logic [n-1:0] c_zero = '0;
   localparam logic [n-1:0] c_one  = {{(n-1){1'b0}}, 1'b1};

   logic [n-1:0] q_q,      q_d;
   logic [n-1:0] reload_q, reload_d;
   state_t       state_q,  state_d;
   logic         expire_q, expire_d;
   logic         busy_q,   busy_d;

   // Next-state / next-count logic
   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      state_d  = state_q;
      expire_d = 1'b0;

      if (load) begin
         q_d      = load_value;
         reload_d = load_value;
         if (load_value != c_zero) begin
            state_d = COUNT;
         end else begin
            // A zero load expires immediately
            state_d  = DONE;
            expire_d = 1'b1;
         end
      end else begin
         case (state_q)
            COUNT: begin
               if (en) begin
                  if (q_q > c_one) begin
                     q_d = q_q - c_one;
                  end else if (q_q == c_one) begin
                     q_d      = c_zero;
                     expire_d = 1'b1;
                     if (!auto_reload) begin
                        state_d = DONE;
                     end
                  end else begin
                     // Q == 0: reload replaces the wrap; if auto-reload was
                     // dropped while parked at zero, finish instead.
                     if (auto_reload) begin
                        q_d = reload_q;
                     end else begin
                        state_d = DONE;
                     end
                  end
               end
            end
            default: begin
               // IDLE and DONE hold until a load arrives
            end
         endcase
      end

      busy_d = (state_d == COUNT);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q      <= c_zero;
         reload_q <= c_zero;
         state_q  <= IDLE;
         expire_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         q_q      <= q_d;
         reload_q <= reload_d;
         state_q  <= state_d;
         expire_q <= expire_d;
         busy_q   <= busy_d;
      end
   end

   assign Q      = q_q;
   assign expire = expire_q;
   assign busy   = busy_q;

endmodule : down_timer
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_down_timer                                              |
// | Description : Directed self-checking bench for down_timer (n = 4).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_down_timer;

   localparam int N = 4;

   logic         clk;
   logic         reset;
   logic         load;
   logic [N-1:0] load_value;
   logic         auto_reload;
   logic         en;
   logic [N-1:0] Q;
   logic         expire;
   logic         busy;

   int n_cmp;
   int n_bad;

   down_timer #(.n(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_value  (load_value),
      .auto_reload (auto_reload),
      .en          (en),
      .Q           (Q),
      .expire      (expire),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int q, input int e, input int b);
      chk({tag, ".Q"},      int'(Q),      q);
      chk({tag, ".expire"}, int'(expire), e);
      chk({tag, ".busy"},   int'(busy),   b);
   endtask

   // Advance one clock edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v);
      load       = 1'b1;
      load_value = N'(v);
      tick();
      load       = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      reset       = 1'b1;
      load        = 1'b0;
      load_value  = '0;
      auto_reload = 1'b0;
      en          = 1'b0;
      tick();
      tick();
      chk3("rst", 0, 0, 0);
      reset = 1'b0;
      tick();

      // Reset mid-count at Q=5 acts before the next edge
      en = 1'b0;
      do_load(5);
      chk3("pre_rst", 5, 0, 1);
      #2 reset = 1'b1;
      #1 chk3("async_rst", 0, 0, 0);
      #2 reset = 1'b0;
      en = 1'b1;
      tick();
      tick();
      chk3("idle_after_rst", 0, 0, 0);

      // One-shot from 3
      auto_reload = 1'b0;
      en          = 1'b1;
      do_load(3);
      chk3("os_3", 3, 0, 1);
      tick(); chk3("os_2", 2, 0, 1);
      tick(); chk3("os_1", 1, 0, 1);
      tick(); chk3("os_0", 0, 1, 0);
      tick(); chk3("os_hold", 0, 0, 0);

      // Auto-reload from 2: period of 3
      auto_reload = 1'b1;
      do_load(2);
      chk3("ar_2a", 2, 0, 1);
      tick(); chk3("ar_1a", 1, 0, 1);
      tick(); chk3("ar_0a", 0, 1, 1);
      tick(); chk3("ar_2b", 2, 0, 1);
      tick(); chk3("ar_1b", 1, 0, 1);
      tick(); chk3("ar_0b", 0, 1, 1);
      // Drop auto-reload while parked at zero: next enabled edge finishes
      auto_reload = 1'b0;
      tick(); chk3("ar_drop", 0, 0, 0);

      // Gated enable from 4
      en = 1'b0;
      do_load(4);
      chk3("en_4", 4, 0, 1);
      en = 1'b1; tick(); chk3("en_e1", 3, 0, 1);
      en = 1'b0; tick(); chk3("en_e0a", 3, 0, 1);
      en = 1'b0; tick(); chk3("en_e0b", 3, 0, 1);
      en = 1'b1; tick(); chk3("en_e1b", 2, 0, 1);
      en = 1'b1; tick(); chk3("en_e1c", 1, 0, 1);
      en = 1'b0; tick(); chk3("en_e0c", 1, 0, 1);
      en = 1'b1; tick(); chk3("en_e1d", 0, 1, 0);
      en = 1'b0; tick(); chk3("en_pulse_end", 0, 0, 0);

      // Load overrides enable mid-count
      en = 1'b1;
      do_load(5);
      tick(); tick(); tick();
      chk3("ovr_pre", 2, 0, 1);
      do_load(9);
      chk3("ovr_9", 9, 0, 1);
      tick(); chk3("ovr_8", 8, 0, 1);
      tick(); chk3("ovr_7", 7, 0, 1);

      // Zero load goes straight to DONE with a single pulse
      auto_reload = 1'b1;
      do_load(0);
      chk3("z_load", 0, 1, 0);
      tick(); chk3("z_hold", 0, 0, 0);
      tick(); chk3("z_hold2", 0, 0, 0);

      // Full-scale one-shot: 15 edges to expire, no wrap
      auto_reload = 1'b0;
      do_load(15);
      chk3("fs_15", 15, 0, 1);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk3($sformatf("fs_%0d", 15 - i), 15 - i, (i == 15) ? 1 : 0,
              (i == 15) ? 0 : 1);
      end
      tick(); chk3("fs_nowrap", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_down_timer
`default_nettype wire
